// File: rtl/dec_pkg.sv
// dec_pkg: shared definitions for the dec_scan_nx decoder/scan sequencer.
//   mode_e  - encoding of the 2-bit mode input
//   clog2() - ceil(log2(value)) for elaboration-time sizing
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    for (v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dec_scan_nx_if.sv
// dec_scan_nx_if: control/status bundle of the dec_scan_nx decoder.
//   en, mode, I, load : driven by the master (controller)
//   Y, idx, wrap      : registered outputs of the decoder (slave)
//   err               : only present when DEC_SCAN_RANGE_ERR_EN is defined
interface dec_scan_nx_if #(
  parameter int N    = 3,
  parameter int NOUT = 8
);
  logic            en;
  logic [1:0]      mode;
  logic [N-1:0]    I;
  logic            load;
  logic [NOUT-1:0] Y;
  logic [N-1:0]    idx;
  logic            wrap;
`ifdef DEC_SCAN_RANGE_ERR_EN
  logic            err;
`endif

  modport master (
    output en, mode, I, load,
`ifdef DEC_SCAN_RANGE_ERR_EN
    input  err,
`endif
    input  Y, idx, wrap
  );

  modport slave (
    input  en, mode, I, load,
`ifdef DEC_SCAN_RANGE_ERR_EN
    output err,
`endif
    output Y, idx, wrap
  );
endinterface

// File: rtl/dec_onehot.sv
// dec_onehot: combinational N-bit index to NOUT-bit one-hot decode.
//   i_idx      : index to decode
//   o_onehot   : one-hot of i_idx, all zero when i_idx >= NOUT
//   o_in_range : i_idx < NOUT
module dec_onehot #(
  parameter int N    = 3,
  parameter int NOUT = 8
) (
  input  logic [N-1:0]    i_idx,
  output logic [NOUT-1:0] o_onehot,
  output logic            o_in_range
);
  localparam logic [N:0] NOUT_W = (N+1)'(NOUT);

  always_comb begin
    o_onehot   = '0;
    o_in_range = ({1'b0, i_idx} < NOUT_W);
    for (int k = 0; k < NOUT; k++) begin
      o_onehot[k] = ({1'b0, i_idx} == (N+1)'(k));
    end
  end
endmodule

// File: rtl/dec_scan_nx.sv
// dec_scan_nx: registered binary-to-one-hot decoder with scan sequencer.
// Modes: direct decode, scan up, scan down, hold; a scan step happens every
// DWELL cycles. Optional macro DEC_SCAN_RANGE_ERR_EN adds bus.err, a one-cycle
// flag for out-of-range direct decode or a clamped load.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : dec_scan_nx_if.slave (en, mode, I, load -> Y, idx, wrap[, err])
module dec_scan_nx #(
  parameter int N     = 3,
  parameter int NOUT  = 8,
  parameter int DWELL = 1
) (
  input logic          clk,
  input logic          rst,
  dec_scan_nx_if.slave bus
);
  import dec_pkg::*;

  localparam int             CW      = clog2(DWELL) + 1;
  localparam logic [CW-1:0]  DW_LAST = CW'(DWELL - 1);
  localparam logic [N:0]     NOUT_W  = (N+1)'(NOUT);
  localparam logic [N-1:0]   IDX_MAX = N'(NOUT - 1);

  logic [N-1:0]    r_idx;
  logic [CW-1:0]   r_cnt;
  mode_e           r_mode_prev;
  logic [NOUT-1:0] r_y;
  logic            r_wrap;

  logic [N-1:0]    w_idx_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_wrap_nxt;
  logic            w_y_zero;
  logic            w_i_ok;
  logic            w_step;
  logic            w_mode_chg;
  logic [NOUT-1:0] w_onehot;
  logic            w_nxt_ok;
  mode_e           w_mode;

  assign w_mode     = mode_e'(bus.mode);
  assign w_i_ok     = ({1'b0, bus.I} < NOUT_W);
  assign w_step     = (r_cnt == DW_LAST);
  assign w_mode_chg = (w_mode != r_mode_prev);

  // Priority: en=0 > direct > load > mode change > hold/scan.
  // A mode-change edge only clears the dwell counter; it never steps, so the
  // first step in the new mode lands DWELL edges later.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_y_zero   = 1'b0;
    if (!bus.en) begin
      w_y_zero = 1'b1;
    end else if (w_mode == MODE_DIRECT) begin
      w_idx_nxt = bus.I;
      w_cnt_nxt = '0;
    end else if (bus.load) begin
      w_idx_nxt = w_i_ok ? bus.I : IDX_MAX;
      w_cnt_nxt = '0;
    end else if (w_mode_chg) begin
      w_cnt_nxt = '0;
    end else if (w_mode == MODE_HOLD) begin
      w_cnt_nxt = r_cnt;
    end else if (!w_step) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = '0;
      if (w_mode == MODE_UP) begin
        if (r_idx >= IDX_MAX) begin
          w_idx_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + N'(1);
        end
      end else begin
        if (r_idx == '0) begin
          w_idx_nxt  = IDX_MAX;
          w_wrap_nxt = 1'b1;
        end else if (r_idx > IDX_MAX) begin
          // stale out-of-range index from a direct decode: re-enter at the top
          w_idx_nxt = IDX_MAX;
        end else begin
          w_idx_nxt = r_idx - N'(1);
        end
      end
    end
  end

  dec_onehot #(.N(N), .NOUT(NOUT)) u_onehot (
    .i_idx      (w_idx_nxt),
    .o_onehot   (w_onehot),
    .o_in_range (w_nxt_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_mode_prev <= MODE_DIRECT;
      r_y         <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
      r_y    <= (w_y_zero || !w_nxt_ok) ? '0 : w_onehot;
      if (bus.en) r_mode_prev <= w_mode;
    end
  end

  assign bus.Y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

`ifdef DEC_SCAN_RANGE_ERR_EN
  logic r_err;
  logic w_err_nxt;

  // out-of-range I matters only when it is consumed: direct decode or load
  assign w_err_nxt = bus.en && !w_i_ok && ((w_mode == MODE_DIRECT) || bus.load);

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_nxt;
  end

  assign bus.err = r_err;
`endif
endmodule
